// File: rtl/universal_window_counter.sv
// -----------------------------------------------------------------------------
// universal_window_counter
//
// Up/down counter confined to a runtime-programmable window [lo, hi] with a
// programmable step. It wraps to the opposite limit or saturates at
// the limit it reached. Used as a timebase, address sequencer and PWM
// period source.
//
// Optional feature macro: WCNT_PRESCALER_EN
//   - When defined, a count event happens only once per PRESC enabled
//     cycles.
//   - When undefined, every enabled cycle is a count event and PRESC is
//     ignored.
//
// Parameters
//   N       counter / limit / load width
//   STEP_W  step input width (assumed <= N); a step of 0 counts as 1
//   PRESC   enable prescale ratio (>= 1), WCNT_PRESCALER_EN only
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   load       synchronous load of D into Q (beats en)
//   en         count enable
//   up         1 = count up, 0 = count down
//   sat        1 = saturate at window edge, 0 = wrap to opposite edge
//   step       count magnitude
//   lo, hi     inclusive window limits (lo <= hi)
//   D          load value (loaded unclamped)
//   Q          counter value
//   max_tick   Q == hi (combinational)
//   min_tick   Q == lo (combinational)
//   wrap_tick  registered one-cycle pulse on a wrap/saturate event
// -----------------------------------------------------------------------------
module universal_window_counter #(
    parameter int N      = 8,
    parameter int STEP_W = 4,
    parameter int PRESC  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic              up,
    input  logic              sat,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      lo,
    input  logic [N-1:0]      hi,
    input  logic [N-1:0]      D,
    output logic [N-1:0]      Q,
    output logic              max_tick,
    output logic              min_tick,
    output logic              wrap_tick
);

    // Two guard bits: one for carry out of Q+s, one for sign of Q-s.
    localparam int AW = N + 2;

    logic                 count_event;
    logic [STEP_W-1:0]    s_mag;
    logic signed [AW-1:0] q_ext;
    logic signed [AW-1:0] lo_ext;
    logic signed [AW-1:0] hi_ext;
    logic signed [AW-1:0] s_ext;
    logic signed [AW-1:0] sum_up;
    logic signed [AW-1:0] diff_dn;
    logic                 outside;
    logic [N-1:0]         q_next;
    logic                 wrap_next;

    assign s_mag   = (step == '0) ? STEP_W'(1) : step;
    assign q_ext   = $signed({2'b00, Q});
    assign lo_ext  = $signed({2'b00, lo});
    assign hi_ext  = $signed({2'b00, hi});
    assign s_ext   = $signed({{(AW - STEP_W){1'b0}}, s_mag});
    assign sum_up  = q_ext + s_ext;
    assign diff_dn = q_ext - s_ext;
    assign outside = (Q < lo) || (Q > hi);

`ifdef WCNT_PRESCALER_EN
    localparam int            PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic [PW-1:0] presc;

    // Advances on enabled cycles only, so en=0 freezes the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc <= '0;
        else if (load)
            presc <= '0;
        else if (en)
            presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end

    assign count_event = en && !load && (presc == PRESC_LAST);
`else
    assign count_event = en && !load;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        q_next    = Q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = D;
        end else if (count_event) begin
            if (outside) begin
                // Re-entry into the window is not an edge event.
                q_next = up ? lo : hi;
            end else if (up) begin
                if (sum_up <= hi_ext) begin
                    q_next = sum_up[N-1:0];
                end else if (!(sat && Q == hi)) begin
                    // Already parked at hi in saturate mode: hold silently so
                    // the pulse fires once per saturation.
                    q_next    = sat ? hi : lo;
                    wrap_next = 1'b1;
                end
            end else begin
                if (diff_dn >= lo_ext) begin
                    q_next = diff_dn[N-1:0];
                end else if (!(sat && Q == lo)) begin
                    q_next    = sat ? lo : hi;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            Q         <= '0;
            wrap_tick <= 1'b0;
        end else begin
            Q         <= q_next;
            wrap_tick <= wrap_next;
        end
    end

    assign max_tick = (Q == hi);
    assign min_tick = (Q == lo);

endmodule

// File: tb/tb_universal_window_counter.sv
// -----------------------------------------------------------------------------
// tb_universal_window_counter
//
// Directed self-checking bench for universal_window_counter (N=8, STEP_W=4).
// Each task drives one scenario and compares Q / ticks against hand-computed
// values. Inputs change and outputs are sampled 1 time unit after the rising
// edge. The prescaler scenario runs only when WCNT_PRESCALER_EN is defined.
// -----------------------------------------------------------------------------
module tb_universal_window_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       sat = 1'b0;
    logic [3:0] step = 4'd1;
    logic [7:0] lo = 8'd0;
    logic [7:0] hi = 8'd255;
    logic [7:0] D = 8'd0;
    logic [7:0] Q;
    logic       max_tick;
    logic       min_tick;
    logic       wrap_tick;

    int n_checks = 0;
    int n_fail   = 0;

    universal_window_counter #(.N(8), .STEP_W(4), .PRESC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .en        (en),
        .up        (up),
        .sat       (sat),
        .step      (step),
        .lo        (lo),
        .hi        (hi),
        .D         (D),
        .Q         (Q),
        .max_tick  (max_tick),
        .min_tick  (min_tick),
        .wrap_tick (wrap_tick)
    );

    always #5 clk = ~clk;

    task automatic clk_step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_value(input logic [7:0] v);
        load = 1'b1;
        D    = v;
        clk_step();
        load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clk_step();
        n_checks++;
        if (Q !== 8'd0) begin n_fail++; $display("FAIL reset_q: Q=%0d expected 0", Q); end
        n_checks++;
        if (wrap_tick !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: wrap_tick=%b expected 0", wrap_tick); end
        n_checks++;
        if ({max_tick, min_tick} !== 2'b01) begin
            n_fail++; $display("FAIL reset_ticks: max/min=%b expected 01", {max_tick, min_tick});
        end
        rst = 1'b0;
    endtask

    task automatic test_load;
        load_value(8'h37);
        n_checks++;
        if (Q !== 8'h37 || wrap_tick !== 1'b0) begin
            n_fail++; $display("FAIL load: Q=%h wrap=%b expected 37/0", Q, wrap_tick);
        end
        load = 1'b1; en = 1'b1; D = 8'h10;
        clk_step();
        load = 1'b0; en = 1'b0;
        n_checks++;
        if (Q !== 8'h10) begin n_fail++; $display("FAIL load_beats_en: Q=%h expected 10", Q); end
    endtask

    task automatic test_wrap_up;
        logic [7:0] eq[4] = '{8'd13, 8'd16, 8'd19, 8'd10};
        logic       ew[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        lo = 8'd10; hi = 8'd20; step = 4'd3; up = 1'b1; sat = 1'b0;
        load_value(8'd10);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_step();
            n_checks++;
            if (Q !== eq[i] || wrap_tick !== ew[i] || min_tick !== (eq[i] == 8'd10)) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: Q=%0d wrap=%b min=%b expected %0d/%b/%b",
                         i, Q, wrap_tick, min_tick, eq[i], ew[i], eq[i] == 8'd10);
            end
        end
        en = 1'b0;
        clk_step();
        n_checks++;
        if (Q !== 8'd10 || wrap_tick !== 1'b0) begin
            n_fail++; $display("FAIL hold: Q=%0d wrap=%b expected 10/0", Q, wrap_tick);
        end
    endtask

    task automatic test_saturate_up;
        logic ew[3] = '{1'b1, 1'b0, 1'b0};
        sat = 1'b1;
        load_value(8'd19);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            n_checks++;
            if (Q !== 8'd20 || wrap_tick !== ew[i] || max_tick !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_up[%0d]: Q=%0d wrap=%b max=%b expected 20/%b/1",
                         i, Q, wrap_tick, max_tick, ew[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_step_zero_down;
        logic [7:0] eq[3] = '{8'd5, 8'd7, 8'd6};
        logic       ew[3] = '{1'b0, 1'b1, 1'b0};
        up = 1'b0; step = 4'd0; lo = 8'd5; hi = 8'd7; sat = 1'b0;
        load_value(8'd6);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            n_checks++;
            if (Q !== eq[i] || wrap_tick !== ew[i]) begin
                n_fail++;
                $display("FAIL step0_down[%0d]: Q=%0d wrap=%b expected %0d/%b", i, Q, wrap_tick, eq[i], ew[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_saturate_down;
        logic ew[2] = '{1'b1, 1'b0};
        lo = 8'd10; hi = 8'd20; step = 4'd2; up = 1'b0; sat = 1'b1;
        load_value(8'd11);
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clk_step();
            n_checks++;
            if (Q !== 8'd10 || wrap_tick !== ew[i]) begin
                n_fail++;
                $display("FAIL sat_down[%0d]: Q=%0d wrap=%b expected 10/%b", i, Q, wrap_tick, ew[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_outside_window;
        lo = 8'd10; hi = 8'd20; step = 4'd1; up = 1'b0; sat = 1'b0;
        load_value(8'd200);
        n_checks++;
        if (Q !== 8'd200 || max_tick !== 1'b0 || min_tick !== 1'b0) begin
            n_fail++; $display("FAIL load_unclamped: Q=%0d max=%b min=%b expected 200/0/0", Q, max_tick, min_tick);
        end
        en = 1'b1;
        clk_step();
        en = 1'b0;
        n_checks++;
        if (Q !== 8'd20 || wrap_tick !== 1'b0 || max_tick !== 1'b1) begin
            n_fail++; $display("FAIL reentry_down: Q=%0d wrap=%b max=%b expected 20/0/1", Q, wrap_tick, max_tick);
        end
    endtask

    task automatic test_single_point;
        lo = 8'd9; hi = 8'd9; step = 4'd1; up = 1'b1; sat = 1'b0;
        load_value(8'd9);
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clk_step();
            n_checks++;
            if (Q !== 8'd9 || wrap_tick !== 1'b1) begin
                n_fail++; $display("FAIL point_wrap[%0d]: Q=%0d wrap=%b expected 9/1", i, Q, wrap_tick);
            end
        end
        sat = 1'b1;
        clk_step();
        n_checks++;
        if (Q !== 8'd9 || wrap_tick !== 1'b0) begin
            n_fail++; $display("FAIL point_sat: Q=%0d wrap=%b expected 9/0", Q, wrap_tick);
        end
        en = 1'b0; sat = 1'b0;
    endtask

    task automatic test_reset_midcount;
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        lo = 8'd50; hi = 8'd60; step = 4'd1; up = 1'b1; sat = 1'b0;
        en = 1'b1;
        clk_step();
        n_checks++;
        if (Q !== 8'd50 || wrap_tick !== 1'b0) begin
            n_fail++; $display("FAIL reentry_up: Q=%0d wrap=%b expected 50/0", Q, wrap_tick);
        end
        clk_step();
        n_checks++;
        if (Q !== 8'd51) begin n_fail++; $display("FAIL count_51: Q=%0d expected 51", Q); end
        rst = 1'b1;
        #2;
        n_checks++;
        if (Q !== 8'd0) begin n_fail++; $display("FAIL async_reset: Q=%0d expected 0", Q); end
        #1;
        rst = 1'b0;
        clk_step();
        n_checks++;
        if (Q !== 8'd50 || wrap_tick !== 1'b0) begin
            n_fail++; $display("FAIL after_reset: Q=%0d wrap=%b expected 50/0", Q, wrap_tick);
        end
        en = 1'b0;
    endtask

`ifdef WCNT_PRESCALER_EN
    task automatic test_prescaler;
        logic [7:0] eq_tail[4] = '{8'd3, 8'd3, 8'd3, 8'd4};
        logic       en_tail[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        lo = 8'd0; hi = 8'd255; step = 4'd1; up = 1'b1; sat = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            clk_step();
            n_checks++;
            if (Q !== 8'(k / 4)) begin
                n_fail++; $display("FAIL presc_run[%0d]: Q=%0d expected %0d", k, Q, k / 4);
            end
        end
        // Two more enabled cycles leave the prescaler at phase 2.
        clk_step();
        clk_step();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            clk_step();
            n_checks++;
            if (Q !== 8'd3) begin n_fail++; $display("FAIL presc_hold[%0d]: Q=%0d expected 3", k, Q); end
        end
        // Phase 2 resumes: one cycle to phase 3, the next is the count event.
        en = 1'b1;
        clk_step();
        n_checks++;
        if (Q !== 8'd3) begin n_fail++; $display("FAIL presc_phase3: Q=%0d expected 3", Q); end
        clk_step();
        n_checks++;
        if (Q !== 8'd4) begin n_fail++; $display("FAIL presc_resume: Q=%0d expected 4", Q); end
        en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_wrap_up();
        test_saturate_up();
        test_step_zero_down();
        test_saturate_down();
        test_outside_window();
        test_single_point();
        test_reset_midcount();
`ifdef WCNT_PRESCALER_EN
        test_prescaler();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
